// File: rtl/awg_pkg.sv
// Shared types and constants for the AWG phase-accumulator waveform generator.
package awg_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int DAC_W_DEF   = 14;

  localparam logic [DAC_W_DEF-1:0] MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    WAVE_SAW  = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SQR  = 2'd2,
    WAVE_HOLD = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

endpackage

// File: rtl/awg_wave_map.sv
// Registered phase-to-sample mapper: one clock from truncated phase to offset-binary DAC code.
module awg_wave_map
  import awg_pkg::*;
#(
  parameter int DAC_W = DAC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DAC_W-1:0] p,
  input  wave_e            wave,
  input  logic [7:0]       duty,
  output logic [DAC_W-1:0] da_data,
  output logic             da_valid
);

  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  // Square compares the top 8 phase bits against duty, so duty 0 never goes high.
  function automatic logic [DAC_W-1:0] map_sample(input logic [DAC_W-1:0] ph,
                                                  input wave_e          wv,
                                                  input logic [7:0]     dt);
    logic [DAC_W-1:0] tri_up;
    tri_up = {ph[DAC_W-2:0], 1'b0};
    case (wv)
      WAVE_SAW: map_sample = ph;
      WAVE_TRI: map_sample = ph[DAC_W-1] ? ~tri_up : tri_up;
      WAVE_SQR: map_sample = (ph[DAC_W-1 -: 8] < dt) ? {DAC_W{1'b1}} : {DAC_W{1'b0}};
      default:  map_sample = MID;
    endcase
  endfunction

  logic [DAC_W-1:0] sample_p0;

  always_comb begin
    sample_p0 = MID;
    if (en) sample_p0 = map_sample(p, wave, duty);
  end

  // p0 -> p1: sample register feeding the DAC output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      da_data  <= MID;
      da_valid <= 1'b0;
    end else begin
      da_data  <= sample_p0;
      da_valid <= en;
    end
  end

endmodule

// File: rtl/awg_wave_gen.sv
// Phase-accumulator waveform generator; config changes are deferred to a phase wrap.
module awg_wave_gen
  import awg_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DAC_W   = DAC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_wave,
  input  logic [7:0]         cfg_duty,
  output logic [DAC_W-1:0]   da_data,
  output logic               da_valid,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_p0;
  logic [PHASE_W:0]   sum_p0;
  logic               carry_p0;
  logic               carry_p1;

  logic [PHASE_W-1:0] act_ftw;
  wave_e              act_wave;
  logic [7:0]         act_duty;
  logic [PHASE_W-1:0] pend_ftw;
  wave_e              pend_wave;
  logic [7:0]         pend_duty;

  logic cfg_acc;
  logic load_act;
  logic act_from_pend;
  logic load_pend;

  assign cfg_ready = (state_q != PEND);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign sum_p0    = {1'b0, phase_p0} + {1'b0, act_ftw};
  assign carry_p0  = sum_p0[PHASE_W];

  // A cfg accepted in RUN always waits for a later carry, even if one happens on the accepting edge.
  always_comb begin
    state_d       = state_q;
    load_act      = 1'b0;
    act_from_pend = 1'b0;
    load_pend     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      if (state_q == PEND) act_from_pend = 1'b1;
      else if (cfg_acc)    load_act      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          if (cfg_acc) load_act = 1'b1;
        end
        RUN: begin
          if (cfg_acc) begin
            state_d   = PEND;
            load_pend = 1'b1;
          end
        end
        PEND: begin
          // With ftw 0 the accumulator never wraps, so release the pending cfg at once.
          if (carry_p0 || (act_ftw == '0)) begin
            state_d       = RUN;
            act_from_pend = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_ftw  <= '0;
      act_wave <= WAVE_SAW;
      act_duty <= 8'h80;
    end else if (act_from_pend) begin
      act_ftw  <= pend_ftw;
      act_wave <= pend_wave;
      act_duty <= pend_duty;
    end else if (load_act) begin
      act_ftw  <= cfg_ftw;
      act_wave <= wave_e'(cfg_wave);
      act_duty <= cfg_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (load_pend) begin
      pend_ftw  <= cfg_ftw;
      pend_wave <= wave_e'(cfg_wave);
      pend_duty <= cfg_duty;
    end
  end

  // p0: phase accumulator; carry is delayed a stage so wrap lines up with the wrapped sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_p0 <= '0;
      carry_p1 <= 1'b0;
      wrap     <= 1'b0;
    end else if (en) begin
      phase_p0 <= sum_p0[PHASE_W-1:0];
      carry_p1 <= carry_p0;
      wrap     <= carry_p1;
    end else begin
      phase_p0 <= '0;
      carry_p1 <= 1'b0;
      wrap     <= 1'b0;
    end
  end

  awg_wave_map #(
    .DAC_W(DAC_W)
  ) u_map (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .p       (phase_p0[PHASE_W-1 -: DAC_W]),
    .wave    (act_wave),
    .duty    (act_duty),
    .da_data (da_data),
    .da_valid(da_valid)
  );

endmodule

// File: doc/awg_wave_gen.md
# awg_wave_gen

Phase-accumulator waveform generator for the AWG datapath; sits directly upstream of the DAC output register and produces one 14-bit offset-binary sample per clock. It produces sawtooth, triangle, variable-duty square and midscale-hold waveforms. Frequency, waveform and duty are loaded through a valid/ready config port and take effect only at a phase wrap, so the DAC never sees a mid-period glitch.

## Interface
- PHASE_W, 32, phase accumulator width (≥ DAC_W+2)
- DAC_W, 14, sample width
- clk  in  1  sample clock (DAC clock domain); one clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low = idle, phase cleared
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready
- cfg_ftw  in  PHASE_W  frequency tuning word
- cfg_wave  in  2  0 saw, 1 triangle, 2 square, 3 midscale hold
- cfg_duty  in  8  square high fraction, duty/256
- da_data  out  DAC_W  sample to DAC register
- da_valid  out  1  da_data is a live sample
- wrap  out  1  one-cycle pulse on accumulator carry-out

## Operation
- Reset values: phase 0, active cfg {ftw 0, wave 0, duty 0x80}, no pending cfg, da_data 0x2000 (MIDSCALE), da_valid 0, wrap 0, cfg_ready 1.
- States: IDLE (en=0), RUN (en=1, no pending), PEND (en=1, pending cfg held). cfg_ready = 1 in IDLE and RUN, 0 in PEND.
- IDLE: accepted cfg is applied to the active registers on the accepting edge; phase held at 0; da_data = MIDSCALE, da_valid 0.
- IDLE→RUN on en=1. RUN→PEND on cfg accept. PEND→RUN on wrap edge, when the pending cfg is copied to active. Any state→IDLE on en=0, and a pending cfg is applied immediately.
- Active ftw == 0 in PEND: no wrap can occur, so the pending cfg is applied on the next edge.
- Phase: phase <= phase + ftw mod 2^PHASE_W each RUN/PEND cycle. Carry-out sets wrap next cycle. The addition producing the carry uses the old ftw; the new ftw is used from the following addition.
- Mapping, with p = phase[PHASE_W-1 -: DAC_W]:
  - saw: p.
  - triangle: p[13] ? ~{p[12:0],1'b0} : {p[12:0],1'b0}.
  - square: (p[13:6] < duty) ? 0x3FFF : 0x0000. duty 0 gives constant low.
  - hold: 0x2000.
- Simultaneous accept and wrap in RUN: the cfg goes to pending and applies at the next wrap, not the current one.

## Timing
- Sample latency is 1 clock. da_data at edge n+1 = map(phase at edge n, active cfg at edge n).
- First edge with en=1: da_data <= map(0), da_valid <= 1, phase <= ftw.
- en falling: da_valid 0 and da_data MIDSCALE on the next edge.
- wrap pulse aligns with the first sample computed from the wrapped phase.
- Async rst mid-run: outputs take reset values immediately, and any pending cfg is discarded.

## Structure
- Package awg_pkg:
  - wave codes WAVE_SAW/TRI/SQR/HOLD
  - MIDSCALE
  - DAC_W and PHASE_W defaults
  - state enum IDLE/RUN/PEND
- Sub-module awg_wave_map: registered phase-to-sample mapper (p, wave, duty → da_data). The top level holds the accumulator, config shadow and FSM.

## Test plan
- Reset, then idle with en=0 → da_data 0x2000, da_valid 0, cfg_ready 1.
- ftw 0x4000_0000, saw, en=1 → da_data 0x0000, 0x1000, 0x2000, 0x3000 repeating; wrap every 4th cycle.
- Same ftw, triangle → 0x0000, 0x2000, 0x3FFF, 0x1FFF repeating.
- Same ftw, square, duty 0x80 → 0x3FFF, 0x3FFF, 0x0000, 0x0000. Repeat with duty 0 → all 0x0000.
- Running saw at ftw 2^30, offer ftw 2^31 one cycle after a wrap → cfg_ready drops. Remaining old-rate samples finish, and the new rate starts only after the wrap. Additionally, accept a cfg on the same cycle as a wrap → it applies one period later.
- Assert rst mid-PEND → immediate reset values and the pending cfg is lost. Also drop en during PEND → the pending cfg becomes active and the output is MIDSCALE.
